// File: rtl/ctrl_bus_master.sv
// ---------------------------------------------------------------------------
// ctrl_bus_master
//
// Turns one upstream command (read or write) into a single strobe on a simple
// responder bus, waits for the read data if needed, and hands back one
// response. Only one transaction is in flight at a time.
//
// Parameters
//   READ_LATENCY   : cycles from the read_req strobe to the cycle data_read is
//                    captured (1..15)
//   TIMEOUT_CYCLES : maximum cycles spent waiting on busy (2..65535); only
//                    used when CTRL_BUS_MASTER_TIMEOUT_EN is defined
//
// Optional feature macro
//   CTRL_BUS_MASTER_TIMEOUT_EN : when defined, a command that sees busy high
//                    for TIMEOUT_CYCLES cycles is abandoned with rsp_error=1
//                    and rsp_data=32'hDEAD_BEEF. When undefined the master
//                    waits on busy indefinitely and rsp_error is tied low.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : upstream command handshake
//   cmd_write/cmd_addr/cmd_data : command fields (1=write)
//   rsp_valid/rsp_ready : downstream response handshake
//   rsp_data/rsp_error  : response payload (0 data for writes)
//   write_req/read_req  : single-cycle strobes to the responder
//   addr/data_write     : responder address / write data
//   data_read           : responder read data
//   busy                : responder cannot take a strobe
// All outputs are driven straight from registers.
// ---------------------------------------------------------------------------
module ctrl_bus_master #(
    parameter int READ_LATENCY   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [25:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_error,
    output logic        write_req,
    output logic        read_req,
    output logic [25:0] addr,
    output logic [31:0] data_write,
    input  logic [31:0] data_read,
    input  logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUSY,
        ISSUE,
        READ_WAIT,
        RESP
    } state_t;

    localparam logic [3:0]  LAT_LAST = 4'(READ_LATENCY);
`ifdef CTRL_BUS_MASTER_TIMEOUT_EN
    // Last WAIT_BUSY cycle allowed with busy high; the counter equals the
    // number of busy cycles already spent.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
`endif

    state_t      state_reg;
    state_t      state_next;
    logic        is_write_reg;
    logic [15:0] wait_cnt_reg;
    logic [3:0]  lat_cnt_reg;
    logic        cmd_ready_reg;
    logic        write_req_reg;
    logic        read_req_reg;
    logic [25:0] addr_reg;
    logic [31:0] data_write_reg;
    logic        rsp_valid_reg;
    logic [31:0] rsp_data_reg;
`ifdef CTRL_BUS_MASTER_TIMEOUT_EN
    logic        rsp_error_reg;
`endif

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    state_next = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!busy) begin
                    state_next = ISSUE;
                end
`ifdef CTRL_BUS_MASTER_TIMEOUT_EN
                else if (wait_cnt_reg >= WAIT_LAST) begin
                    state_next = RESP;
                end
`endif
            end
            ISSUE: begin
                state_next = is_write_reg ? RESP : READ_WAIT;
            end
            READ_WAIT: begin
                // busy is deliberately not looked at here: the responder has
                // already taken the strobe and will deliver on schedule.
                if (lat_cnt_reg == LAT_LAST) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ----------------------------------------------------- registers / outputs
    // Outputs are computed from state_next so that they are registered yet
    // line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            is_write_reg   <= 1'b0;
            wait_cnt_reg   <= '0;
            lat_cnt_reg    <= '0;
            cmd_ready_reg  <= 1'b1;
            write_req_reg  <= 1'b0;
            read_req_reg   <= 1'b0;
            addr_reg       <= '0;
            data_write_reg <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_data_reg   <= '0;
`ifdef CTRL_BUS_MASTER_TIMEOUT_EN
            rsp_error_reg  <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= (state_next == IDLE);
            write_req_reg <= (state_next == ISSUE) && is_write_reg;
            read_req_reg  <= (state_next == ISSUE) && !is_write_reg;
            rsp_valid_reg <= (state_next == RESP);

            case (state_reg)
                IDLE: begin
                    if (cmd_valid && cmd_ready_reg) begin
                        is_write_reg   <= cmd_write;
                        addr_reg       <= cmd_addr;
                        data_write_reg <= cmd_data;
                        wait_cnt_reg   <= '0;
                    end
                end
                WAIT_BUSY: begin
                    if (busy && (wait_cnt_reg != 16'hFFFF)) begin
                        wait_cnt_reg <= wait_cnt_reg + 16'd1;
                    end
`ifdef CTRL_BUS_MASTER_TIMEOUT_EN
                    if (state_next == RESP) begin
                        rsp_data_reg  <= 32'hDEAD_BEEF;
                        rsp_error_reg <= 1'b1;
                    end
`endif
                end
                ISSUE: begin
                    // The cycle after the strobe is latency cycle 1.
                    lat_cnt_reg <= 4'd1;
                    if (is_write_reg) begin
                        rsp_data_reg <= '0;
                    end
`ifdef CTRL_BUS_MASTER_TIMEOUT_EN
                    rsp_error_reg <= 1'b0;
`endif
                end
                READ_WAIT: begin
                    if (lat_cnt_reg == LAT_LAST) begin
                        rsp_data_reg <= data_read;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_reg;
    assign write_req  = write_req_reg;
    assign read_req   = read_req_reg;
    assign addr       = addr_reg;
    assign data_write = data_write_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_data   = rsp_data_reg;
`ifdef CTRL_BUS_MASTER_TIMEOUT_EN
    assign rsp_error  = rsp_error_reg;
`else
    assign rsp_error  = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_bus_master.sv
// ---------------------------------------------------------------------------
// tb_ctrl_bus_master
//
// Table of directed transactions applied back to back, plus hand-written
// sequences for reset during a transaction and for the busy timeout (or the
// indefinite stall when CTRL_BUS_MASTER_TIMEOUT_EN is undefined).
// Inputs are driven and outputs sampled on the falling clock edge. Cycle k
// of a transaction is counted from the cycle in which cmd_valid was accepted
// (k = 0).
// ---------------------------------------------------------------------------
module tb_ctrl_bus_master;

    localparam int RL = 2;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [25:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic        write_req;
    logic        read_req;
    logic [25:0] addr;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        busy;

    ctrl_bus_master #(
        .READ_LATENCY  (RL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_error (rsp_error),
        .write_req (write_req),
        .read_req  (read_req),
        .addr      (addr),
        .data_write(data_write),
        .data_read (data_read),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        write;
        logic [25:0] addr;
        logic [31:0] data;
        int          busy_cycles;
        int          hold;
        logic [31:0] rd_data;
        int          exp_strobe;
        int          exp_rsp;
        logic [31:0] exp_rsp_data;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"},  32'(cmd_ready),  32'd1);
        chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
        chk({tag, "_rsp_data"},   rsp_data,        32'd0);
        chk({tag, "_rsp_error"},  32'(rsp_error),  32'd0);
        chk({tag, "_write_req"},  32'(write_req),  32'd0);
        chk({tag, "_read_req"},   32'(read_req),   32'd0);
        chk({tag, "_addr"},       32'(addr),       32'd0);
        chk({tag, "_data_write"}, data_write,      32'd0);
    endtask

    // Called at a falling edge with the DUT idle; returns at the falling edge
    // of the cycle after the response handshake, so the next call starts a
    // back-to-back command.
    task automatic run_txn(input int idx, input vec_t v);
        int strobes = 0;
        int strobe_cyc = -1;
        int rsp_cyc = -1;
        int wr_seen = 0;
        int rd_seen = 0;
        bit both = 0;
        bit ready_hi = 0;
        bit addr_ok = 1;
        bit stable = 1;
        logic [31:0] d0;
        logic e0;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_data  = v.data;
        busy      = (v.busy_cycles > 0);
        rsp_ready = 1'b0;
        for (int k = 1; k <= 60 && rsp_cyc < 0; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_write = ~v.write;
            cmd_addr  = 26'($urandom);
            cmd_data  = $urandom;
            if (write_req || read_req) begin
                strobes++;
                strobe_cyc = k;
                if (write_req) wr_seen++;
                if (read_req) rd_seen++;
                if (addr !== v.addr || data_write !== v.data) addr_ok = 0;
            end
            if (write_req && read_req) both = 1;
            if (cmd_ready) ready_hi = 1;
            if (rsp_valid) rsp_cyc = k;
            busy = (k <= v.busy_cycles);
            data_read = (strobe_cyc > 0 && k == strobe_cyc + RL) ? v.rd_data
                                                                 : (32'h0BAD_0000 | 32'(k));
        end
        chk("strobe_count",   32'(strobes),    32'd1);
        chk("strobe_cycle",   32'(strobe_cyc), 32'(v.exp_strobe));
        chk("write_req_count", 32'(wr_seen),   v.write ? 32'd1 : 32'd0);
        chk("read_req_count", 32'(rd_seen),    v.write ? 32'd0 : 32'd1);
        chk("addr_data_at_strobe", 32'(addr_ok), 32'd1);
        chk("no_dual_strobe", 32'(both),       32'd0);
        chk("cmd_ready_busy", 32'(ready_hi),   32'd0);
        chk("rsp_cycle",      32'(rsp_cyc),    32'(v.exp_rsp));
        chk("rsp_data",       rsp_data,        v.exp_rsp_data);
        chk("rsp_error",      32'(rsp_error),  32'd0);
        d0 = rsp_data;
        e0 = rsp_error;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== d0 || rsp_error !== e0 || cmd_ready
                || write_req || read_req) stable = 0;
        end
        chk("hold_stable", 32'(stable), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop",  32'(rsp_valid), 32'd0);
        chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
        $display("txn %0d: %s addr=%h strobe@%0d rsp@%0d data=%h err=%0d",
                 idx, v.write ? "write" : "read ", v.addr, strobe_cyc, rsp_cyc, d0, e0);
    endtask

    // Start a read with busy low and assert reset at falling edge at_k.
    task automatic reset_mid(input int at_k, input string tag);
        int strobes = 0;
        int rsps = 0;
        bit ready_lo = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 26'h0000044;
        cmd_data  = 32'h1111_2222;
        busy      = 1'b0;
        for (int k = 1; k <= at_k; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_outputs(tag);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (write_req || read_req) strobes++;
            if (rsp_valid) rsps++;
            if (!cmd_ready) ready_lo = 1;
            data_read = 32'hFFFF_0000 | 32'(k);
        end
        chk({tag, "_no_strobe_after"}, 32'(strobes), 32'd0);
        chk({tag, "_no_rsp_after"},    32'(rsps),    32'd0);
        chk({tag, "_ready_after"},     32'(ready_lo), 32'd0);
        $display("txn reset in %s: strobes=%0d responses=%0d", tag, strobes, rsps);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 26'h0000010, 32'h1234_5678, 0, 0,  32'h0,         2, 3,  32'h0};
        vecs[1] = '{1'b0, 26'h0000004, 32'h0,         0, 0,  32'hCAFE_0001, 2, 5,  32'hCAFE_0001};
        vecs[2] = '{1'b1, 26'h0000155, 32'hA5A5_0F0F, 5, 10, 32'h0,         7, 8,  32'h0};
        vecs[3] = '{1'b0, 26'h00002AA, 32'h0,         5, 3,  32'h5A5A_1234, 7, 10, 32'h5A5A_1234};
        vecs[4] = '{1'b1, 26'h3FFFFFF, 32'hFFFF_FFFF, 1, 0,  32'h0,         3, 4,  32'h0};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        data_read = 32'h0;
        busy      = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_txn(i, vecs[i]);
        end

        reset_mid(1, "wait_busy");
        run_txn(5, vecs[1]);
        reset_mid(3, "read_wait");
        run_txn(6, vecs[0]);

        begin : timeout_seq
            int strobes;
            int rsp_k;
            strobes = 0;
            rsp_k = -1;
            chk("to_cmd_ready", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = 26'h0000020;
            cmd_data  = 32'h0;
            busy      = 1'b1;
            for (int k = 1; k <= 40 && rsp_k < 0; k++) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                if (write_req || read_req) strobes++;
                if (rsp_valid) rsp_k = k;
            end
            chk("to_no_strobe", 32'(strobes), 32'd0);
`ifdef CTRL_BUS_MASTER_TIMEOUT_EN
            chk("to_rsp_cycle", 32'(rsp_k), 32'(TO + 1));
            chk("to_rsp_error", 32'(rsp_error), 32'd1);
            chk("to_rsp_data",  rsp_data, 32'hDEAD_BEEF);
            chk("to_cmd_ready_low", 32'(cmd_ready), 32'd0);
            busy = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            chk("to_rsp_drop", 32'(rsp_valid), 32'd0);
            chk("to_ready_after", 32'(cmd_ready), 32'd1);
            $display("txn timeout: response at cycle %0d, strobes=%0d", rsp_k, strobes);
`else
            chk("stall_no_rsp", 32'(rsp_k), 32'hFFFF_FFFF);
            chk("stall_cmd_ready_low", 32'(cmd_ready), 32'd0);
            busy = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk("stall_ready_after_reset", 32'(cmd_ready), 32'd1);
            $display("txn stall: no response in 40 cycles, strobes=%0d", strobes);
`endif
        end

        run_txn(7, vecs[3]);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_bus_master.md
CTRL_BUS_MASTER -- requirements
Module: ctrl_bus_master

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2: cycles from the read_req pulse to the cycle in which data_read is sampled (range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum number of cycles spent waiting on busy (range 2..65535).
REQ-003 Port: clk  in  1  system clock (150 MHz); the single clock domain.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: cmd_valid  in  1  upstream command present.
REQ-006 Port: cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-007 Port: cmd_write  in  1  1=write, 0=read.
REQ-008 Port: cmd_addr  in  26  target address.
REQ-009 Port: cmd_data  in  32  write data.
REQ-010 Port: rsp_valid  out  1  response present.
REQ-011 Port: rsp_ready  in  1  downstream accepts the response.
REQ-012 Port: rsp_data  out  32  read data; 0 for writes.
REQ-013 Port: rsp_error  out  1  transaction abandoned on timeout.
REQ-014 Port: write_req  out  1  single-cycle write strobe to the responder.
REQ-015 Port: read_req  out  1  single-cycle read strobe to the responder.
REQ-016 Port: addr  out  26  responder address.
REQ-017 Port: data_write  out  32  responder write data.
REQ-018 Port: data_read  in  32  responder read data.
REQ-019 Port: busy  in  1  responder not ready; high means no strobe may be issued.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT_BUSY, ISSUE, READ_WAIT, RESP; all outputs registered.
REQ-021 IDLE: cmd_ready=1; on cmd_valid&cmd_ready in cycle T, latch cmd_write/addr/data and enter WAIT_BUSY at T+1; cmd_ready=0 in all other states.
REQ-022 WAIT_BUSY: if busy==0 then enter ISSUE; otherwise stay and increment the wait counter.
REQ-023 ISSUE: assert exactly one of write_req/read_req for exactly one cycle (T+2 when busy is low at T+1); addr and data_write are held stable from WAIT_BUSY through ISSUE.
REQ-024 Write: ISSUE goes to RESP; rsp_valid=1 at T+3 with rsp_data=0, rsp_error=0.
REQ-025 Read: ISSUE goes to READ_WAIT; data_read is sampled in cycle (strobe cycle + READ_LATENCY); RESP/rsp_valid follow on the next cycle.
REQ-026 RESP: rsp_valid, rsp_data and rsp_error are held stable until rsp_ready=1, then go to IDLE; rsp_valid drops the cycle after the handshake.
REQ-027 busy rising during READ_WAIT SHALL be ignored; the capture still occurs at READ_LATENCY.
REQ-028 No new command SHALL be accepted until the response handshake completes (one outstanding transaction).
REQ-029 write_req and read_req SHALL never be high simultaneously and SHALL never be high while in any state other than ISSUE.
REQ-030 The wait counter is 16 bits, clears on entering WAIT_BUSY, and saturates (no wrap).

Reset
REQ-031 reset SHALL force IDLE, cmd_ready=1 from the first cycle after reset, and rsp_valid=0, rsp_data=0, rsp_error=0, write_req=0, read_req=0, addr=0, data_write=0, counters=0.
REQ-032 reset mid-transaction SHALL discard the pending command and produce no response; no strobe SHALL be issued in the reset cycle.

Configuration
REQ-033 Macro CTRL_BUS_MASTER_TIMEOUT_EN defined: when the wait counter reaches TIMEOUT_CYCLES with busy still high, go to RESP with no strobe issued, rsp_error=1 and rsp_data=32'hDEAD_BEEF.
REQ-034 Macro undefined: WAIT_BUSY waits indefinitely; rsp_error is constant 0; no timeout logic is present.

Verification
REQ-035 busy=0; write addr 26'h0000010, data 32'h12345678 accepted at T -> write_req=1 only at T+2 with those values; rsp_valid at T+3, rsp_data=0, rsp_error=0.
REQ-036 READ_LATENCY=2; read addr 26'h0000004; responder returns 32'hCAFE0001 two cycles after read_req -> rsp_data=32'hCAFE0001, rsp_valid one cycle after capture.
REQ-037 busy held high 5 cycles after accept -> no strobe while busy; strobe exactly 1 cycle after busy falls; exactly one strobe per command.
REQ-038 TIMEOUT_EN defined, TIMEOUT_CYCLES=8, busy stuck high -> rsp_error=1, rsp_data=32'hDEADBEEF, no strobe; with the macro undefined -> stalls and no response.
REQ-039 rsp_ready held low 10 cycles -> response stable and cmd_ready=0 throughout; back-to-back commands are accepted the cycle after the handshake.
REQ-040 reset asserted in READ_WAIT -> no rsp_valid; all outputs at reset values; a subsequent command completes normally.
